cordic_rotation: RTL and testbench

Iterative rotation-mode CORDIC core: the counterpart of the vectoring-mode datapath. It takes a vector (x, y) and a target angle z, rotates the vector by z using shift-add micro-rotations, and returns the gain-scaled rotated vector. It accepts one operation at a time over a start/busy/done handshake. With x = 1/K and y = 0 it produces cos/sin, and it sits beside the vectoring core in the CORDIC datapath.

---
 rtl/cordic_rotation.sv | 177 +++++++++++++++++
 tb/tb_cordic_rotation.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotation.sv
// +-----------------------------------------------------------------------------+
// | cordic_rotation: iterative rotation-mode CORDIC, one micro-rotation/cycle.  |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module cordic_rotation #(
  parameter int WORD_WIDTH = 16,
  parameter int ITERATIONS = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] x_in,
  input  logic [WORD_WIDTH-1:0] y_in,
  input  logic [WORD_WIDTH-1:0] z_in,
  output logic [WORD_WIDTH-1:0] x_out,
  output logic [WORD_WIDTH-1:0] y_out,
  output logic [WORD_WIDTH-1:0] z_out,
  output logic                  busy,
  output logic                  done
);

  localparam int FRAC     = WORD_WIDTH - 3;
  localparam int IW       = $clog2(WORD_WIDTH);
  localparam int TAB_SIZE = 1 << IW;
  localparam logic [63:0] PI_4_Q56 = 64'h00C9_0FDA_A221_68C2;

  // Angle constants are built at elaboration from a 2^-56 fixed-point series.
  function automatic logic [WORD_WIDTH-1:0] round_q56(input logic [63:0] v, input int shift);
    return WORD_WIDTH'((v + (64'd1 << (shift - 1))) >> shift);
  endfunction

  function automatic logic [63:0] atan_q56(input int idx);
    logic [63:0] acc;
    int          e;
    acc = '0;
    if (idx == 0) begin
      acc = PI_4_Q56;
    end else begin
      for (int k = 0; k < 32; k++) begin
        e = 56 - idx * (2 * k + 1);
        if (e >= 0) begin
          if (k[0]) acc = acc - ((64'd1 << e) / 64'(2 * k + 1));
          else      acc = acc + ((64'd1 << e) / 64'(2 * k + 1));
        end
      end
    end
    return acc;
  endfunction

  localparam logic signed [WORD_WIDTH-1:0] HALF_PI = round_q56(PI_4_Q56 << 1, 56 - FRAC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [IW-1:0]                r_i;
  logic signed [WORD_WIDTH-1:0] r_x, r_y, r_z;
  logic [WORD_WIDTH-1:0]        r_x_out, r_y_out, r_z_out;

  logic [WORD_WIDTH-1:0]        w_atan [TAB_SIZE];
  logic signed [WORD_WIDTH-1:0] w_xs, w_ys, w_xn, w_yn, w_zn;
  logic                         w_last;
  logic                         w_accept;

  for (genvar g = 0; g < TAB_SIZE; g++) begin : g_atan
    if (g < WORD_WIDTH - 2) begin : g_entry
      localparam logic [WORD_WIDTH-1:0] ATAN_G = round_q56(atan_q56(g), 56 - FRAC);
      assign w_atan[g] = ATAN_G;
    end else begin : g_pad
      assign w_atan[g] = '0;
    end
  end

  assign w_last   = (r_i == IW'(ITERATIONS - 1));
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_xs     = r_x >>> r_i;
  assign w_ys     = r_y >>> r_i;

  always_comb begin
    w_xn = r_x;
    w_yn = r_y;
    w_zn = r_z;
    if (!r_z[WORD_WIDTH-1]) begin
      w_xn = r_x - w_ys;
      w_yn = r_y + w_xs;
      w_zn = r_z - w_atan[r_i];
    end else begin
      w_xn = r_x + w_ys;
      w_yn = r_y - w_xs;
      w_zn = r_z + w_atan[r_i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_PRE;
      S_PRE: begin
        busy        = 1'b1;
        w_state_nxt = S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? S_PRE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_z_out <= '0;
    end else begin
      if (w_accept) begin
        r_x <= x_in;
        r_y <= y_in;
        r_z <= z_in;
      end
      if (r_state == S_PRE) begin
        r_i <= '0;
        // Boundary angles of exactly +/-pi/2 stay in the CORDIC convergence range.
        if (r_z > HALF_PI) begin
          r_x <= -r_y;
          r_y <= r_x;
          r_z <= r_z - HALF_PI;
        end else if (r_z < -HALF_PI) begin
          r_x <= r_y;
          r_y <= -r_x;
          r_z <= r_z + HALF_PI;
        end
      end
      if (r_state == S_ITER) begin
        r_x <= w_xn;
        r_y <= w_yn;
        r_z <= w_zn;
        r_i <= r_i + 1'b1;
        if (w_last) begin
          r_i     <= '0;
          r_x_out <= w_xn;
          r_y_out <= w_yn;
          r_z_out <= w_zn;
        end
      end
    end
  end

  assign x_out = r_x_out;
  assign y_out = r_y_out;
  assign z_out = r_z_out;

endmodule

`default_nettype wire

// File: tb/tb_cordic_rotation.sv
// +-----------------------------------------------------------------------------+
// | tb_cordic_rotation: directed table, random and handshake checks.            |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_cordic_rotation;

  localparam int W = 16;
  localparam int N = 14;
  localparam logic signed [W-1:0] HP = 16'sd12868;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x_in, y_in, z_in;
  logic [W-1:0] x_out, y_out, z_out;
  logic         busy, done;

  int checks   = 0;
  int failures = 0;
  int pcnt     = 0;

  logic signed [W-1:0] atan_t [N];

  cordic_rotation #(.WORD_WIDTH(W), .ITERATIONS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x_in  (x_in),
    .y_in  (y_in),
    .z_in  (z_in),
    .x_out (x_out),
    .y_out (y_out),
    .z_out (z_out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcnt++;

  task automatic chk(input string nm, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  // Reference: quadrant fold then N shift-add rotations, all in 16-bit wrap arithmetic.
  task automatic model(input logic signed [W-1:0] xi, yi, zi,
                       output logic signed [W-1:0] xo, yo, zo);
    logic signed [W-1:0] x, y, z, t, xs, ys;
    x = xi; y = yi; z = zi;
    if (z > HP) begin
      t = x; x = -y; y = t; z = z - HP;
    end else if (z < -HP) begin
      t = x; x = y; y = -t; z = z + HP;
    end
    for (int i = 0; i < N; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (z >= 0) begin
        x = x - ys; y = y + xs; z = z - atan_t[i];
      end else begin
        x = x + ys; y = y - xs; z = z + atan_t[i];
      end
    end
    xo = x; yo = y; zo = z;
  endtask

  task automatic run_op(input logic signed [W-1:0] xa, ya, za, input bit mid,
                        output logic signed [W-1:0] xo, yo, zo);
    int           k;
    bit           held_ok;
    logic [W-1:0] px, py, pz;
    @(negedge clk);
    px = x_out; py = y_out; pz = z_out;
    start = 1'b1; x_in = xa; y_in = ya; z_in = za;
    @(negedge clk);
    start = 1'b0;
    x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
    chk("busy_after_accept", int'(busy), 1, 0);
    k = 0;
    held_ok = 1'b1;
    while (!done && k < 40) begin
      if (x_out !== px || y_out !== py || z_out !== pz) held_ok = 1'b0;
      @(negedge clk);
      k++;
      start = mid && (k == 3 || k == 10);
      if (start) begin
        x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
      end
    end
    start = 1'b0;
    chk("latency", k, 15, 0);
    chk("busy_low_with_done", int'(busy), 0, 0);
    chk("outputs_held_while_busy", int'(held_ok), 1, 0);
    xo = x_out; yo = y_out; zo = z_out;
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0, 0);
  endtask

  typedef struct {
    logic signed [W-1:0] x, y, z;
    int                  ex, ey;
  } vec_t;

  initial begin
    vec_t                tab [6];
    logic signed [W-1:0] gx, gy, gz, mx, my, mz, ra, rb, rc;
    logic signed [W-1:0] hx [4], hy [4], hz [4];
    int                  base, k;
    bit                  idle_ok;

    for (int i = 0; i < N; i++) atan_t[i] = 16'(int'($atan(1.0 / (2.0 ** i)) * 8192.0));

    tab[0] = '{16'sd9949, 16'sd0, 16'sd0,      16384,  0};
    tab[1] = '{16'sd9949, 16'sd0, 16'sd4289,   14189,  8192};
    tab[2] = '{16'sd9949, 16'sd0, 16'sd25736, -16384,  0};
    tab[3] = '{16'sd9949, 16'sd0, -16'sd12868,  0,    -16384};
    tab[4] = '{16'sd9949, 16'sd0, 16'sd12868,   0,     16384};
    tab[5] = '{16'sd9949, 16'sd0, -16'sd25736, -16384, 0};

    rst_n = 1'b0; start = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_x_out", int'($signed(x_out)), 0, 0);
    chk("reset_y_out", int'($signed(y_out)), 0, 0);
    chk("reset_z_out", int'($signed(z_out)), 0, 0);
    chk("reset_busy", int'(busy), 0, 0);
    rst_n = 1'b1;
    idle_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || busy || x_out != 0 || y_out != 0) idle_ok = 1'b0;
    end
    chk("idle_quiet", int'(idle_ok), 1, 0);

    for (int i = 0; i < 6; i++) begin
      run_op(tab[i].x, tab[i].y, tab[i].z, 1'b0, gx, gy, gz);
      model(tab[i].x, tab[i].y, tab[i].z, mx, my, mz);
      chk($sformatf("vec%0d_x_spec", i), int'(gx), tab[i].ex, 8);
      chk($sformatf("vec%0d_y_spec", i), int'(gy), tab[i].ey, 8);
      chk($sformatf("vec%0d_x_exact", i), int'(gx), int'(mx), 0);
      chk($sformatf("vec%0d_y_exact", i), int'(gy), int'(my), 0);
      chk($sformatf("vec%0d_z_exact", i), int'(gz), int'(mz), 0);
    end

    for (int i = 0; i < 24; i++) begin
      if (i < 16) begin
        ra = 16'($urandom_range(0, 26000) - 13000);
        rb = 16'($urandom_range(0, 26000) - 13000);
      end else begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end
      rc = 16'($urandom_range(0, 51472) - 25736);
      run_op(ra, rb, rc, 1'b0, gx, gy, gz);
      model(ra, rb, rc, mx, my, mz);
      chk($sformatf("rand%0d_x", i), int'(gx), int'(mx), 0);
      chk($sformatf("rand%0d_y", i), int'(gy), int'(my), 0);
      chk($sformatf("rand%0d_z", i), int'(gz), int'(mz), 0);
    end

    ra = 16'sd7000; rb = -16'sd3000; rc = 16'sd20000;
    run_op(ra, rb, rc, 1'b1, gx, gy, gz);
    model(ra, rb, rc, mx, my, mz);
    chk("midstart_x", int'(gx), int'(mx), 0);
    chk("midstart_y", int'(gy), int'(my), 0);
    chk("midstart_z", int'(gz), int'(mz), 0);

    for (int j = 0; j < 4; j++) begin
      hx[j] = 16'($urandom_range(0, 26000) - 13000);
      hy[j] = 16'($urandom_range(0, 26000) - 13000);
      hz[j] = 16'($urandom_range(0, 51472) - 25736);
    end
    @(negedge clk);
    start = 1'b1; x_in = hx[0]; y_in = hy[0]; z_in = hz[0];
    base = pcnt;
    for (int j = 0; j < 4; j++) begin
      k = 0;
      while (!done && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("held%0d_period", j), pcnt - base, 16 * (j + 1), 0);
      model(hx[j], hy[j], hz[j], mx, my, mz);
      chk($sformatf("held%0d_x", j), int'($signed(x_out)), int'(mx), 0);
      chk($sformatf("held%0d_y", j), int'($signed(y_out)), int'(my), 0);
      chk($sformatf("held%0d_z", j), int'($signed(z_out)), int'(mz), 0);
      if (j < 3) begin
        x_in = hx[j+1]; y_in = hy[j+1]; z_in = hz[j+1];
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("held_release_idle", int'(busy), 0, 0);

    @(negedge clk);
    start = 1'b1; x_in = 16'sd5000; y_in = 16'sd4000; z_in = 16'sd9000;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_x_out", int'($signed(x_out)), 0, 0);
    chk("midreset_y_out", int'($signed(y_out)), 0, 0);
    chk("midreset_z_out", int'($signed(z_out)), 0, 0);
    chk("midreset_busy", int'(busy), 0, 0);
    chk("midreset_done", int'(done), 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ra = -16'sd8000; rb = 16'sd6000; rc = -16'sd17000;
    run_op(ra, rb, rc, 1'b0, gx, gy, gz);
    model(ra, rb, rc, mx, my, mz);
    chk("postreset_x", int'(gx), int'(mx), 0);
    chk("postreset_y", int'(gy), int'(my), 0);
    chk("postreset_z", int'(gz), int'(mz), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
